// File: rtl/jtkunio_bank_arb.sv
// Round-robin arbiter sharing one SDRAM read engine between four ROM bank clients and the download write path.
// Optional JTKUNIO_BA0_PRIO_EN: bank 0 (main CPU) pre-empts the round-robin; banks 1-3 rotate among themselves.
module jtkunio_bank_arb #(
  parameter int AW    = 22,
  parameter int BURST = 2,
  parameter int TOUT  = 63
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [AW-1:0]                  ba0_addr,
  input  logic [AW-1:0]                  ba1_addr,
  input  logic [AW-1:0]                  ba2_addr,
  input  logic [AW-1:0]                  ba3_addr,
  input  logic [3:0]                     ba_rd,
  output logic [3:0]                     ba_ack,
  output logic [3:0]                     ba_dst,
  output logic [3:0]                     ba_dok,
  output logic [3:0]                     ba_rdy,
  input  logic                           downloading,
  input  logic [AW-1:0]                  prog_addr,
  input  logic [1:0]                     prog_ba,
  input  logic                           prog_we,
  output logic                           prog_ack,
  output logic                           prog_rdy,
  output logic                           mem_req,
  output logic                           mem_wr,
  output logic [1:0]                     mem_ba,
  output logic [AW-1:0]                  mem_addr,
  input  logic                           mem_ack,
  input  logic                           mem_dst,
  input  logic                           mem_rdy,
  input  logic                           mem_dok,
  output logic                           arb_err,
  output logic [2:0]                     dbg_state,
  output logic [$clog2(BURST+1)-1:0]     dbg_words
);

  localparam int WDW = $clog2(TOUT + 1);
  localparam int WW  = $clog2(BURST + 1);
  localparam logic [WDW-1:0] TOUT_V  = WDW'(TOUT);
  localparam logic [WW-1:0]  BURST_V = WW'(BURST);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DATA  = 3'd2,
    S_PCMD  = 3'd3,
    S_PDATA = 3'd4
  } state_t;

  // Handshakes: ba_rd/prog_we are held by the client until the matching one-cycle
  // ack pulse; mem_req is held by us until the core's one-cycle mem_ack pulse.
  // All data-phase strobes are single-cycle and only meaningful in DATA/PDATA.
  state_t          state;
  logic [1:0]      g;
  logic [1:0]      rr;
  logic [1:0]      pick;
  logic            pick_vld;
  logic [WDW-1:0]  wd;
  logic [WW-1:0]   words;
  logic            wd_hit;
  logic            end_data;
  logic [AW-1:0]   bank_addr [4];

  assign bank_addr[0] = ba0_addr;
  assign bank_addr[1] = ba1_addr;
  assign bank_addr[2] = ba2_addr;
  assign bank_addr[3] = ba3_addr;

  assign wd_hit    = (wd == TOUT_V);
  assign end_data  = mem_rdy | wd_hit;
  assign dbg_state = state;
  assign dbg_words = words;

  // First requester at or after the rotating pointer; lowest offset wins.
  always_comb begin : arbiter
    logic [3:0] req;
    logic [1:0] idx;
    req      = ba_rd;
    idx      = 2'd0;
    pick     = rr;
    pick_vld = 1'b0;
`ifdef JTKUNIO_BA0_PRIO_EN
    req[0]   = 1'b0;
`endif
    for (int i = 3; i >= 0; i--) begin
      idx = rr + 2'(i);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
`ifdef JTKUNIO_BA0_PRIO_EN
    if (ba_rd[0]) begin
      pick     = 2'd0;
      pick_vld = 1'b1;
    end
`endif
  end

  // Strobes are steered with zero latency to the granted client only.
  always_comb begin
    ba_ack   = 4'd0;
    ba_dst   = 4'd0;
    ba_dok   = 4'd0;
    ba_rdy   = 4'd0;
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    case (state)
      S_CMD: ba_ack[g] = mem_ack;
      S_DATA: begin
        ba_dst[g] = mem_dst;
        ba_dok[g] = mem_dok;
        ba_rdy[g] = end_data;
      end
      S_PCMD:  prog_ack = mem_ack;
      S_PDATA: prog_rdy = end_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      g        <= 2'd0;
      rr       <= 2'd0;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_ba   <= 2'd0;
      mem_addr <= '0;
      wd       <= '0;
      words    <= '0;
      arb_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wd    <= '0;
          words <= '0;
          if (downloading && prog_we) begin
            mem_req  <= 1'b1;
            mem_wr   <= 1'b1;
            mem_ba   <= prog_ba;
            mem_addr <= prog_addr;
            state    <= S_PCMD;
          end else if (!downloading && pick_vld) begin
            g        <= pick;
            mem_req  <= 1'b1;
            mem_wr   <= 1'b0;
            mem_ba   <= pick;
            mem_addr <= bank_addr[pick];
            state    <= S_CMD;
          end
        end
        S_CMD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
`ifdef JTKUNIO_BA0_PRIO_EN
            if (g != 2'd0) rr <= g + 2'd1;
`else
            rr <= g + 2'd1;
`endif
            state <= S_DATA;
          end
        end
        S_PCMD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_PDATA;
          end
        end
        S_DATA, S_PDATA: begin
          if (mem_dok && words != BURST_V) words <= words + WW'(1);
          // A missing mem_rdy is replaced by a forced completion so the client never stalls.
          if (end_data) begin
            mem_wr <= 1'b0;
            state  <= S_IDLE;
            if (!mem_rdy) arb_err <= 1'b1;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
